// File: rtl/decode_issue_if.sv
// Fetch / register-file / ALU-operand bundle seen by the decode_issue stage.
// decode_issue connects through the slave modport; fetch, regfile and ALU models use master.
interface decode_issue_if;
  logic        ir_valid_i;
  logic [31:0] ir_i;
  logic [31:0] pc_i;
  logic        ir_ready_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] readd_a_o;
  logic [31:0] readd_b_o;
  logic [31:0] readd_pass_o;
  logic        readin_a_o;
  logic        readin_b_o;
  logic        readin_pass_o;
  logic [2:0]  stage_o;
  logic [31:0] ir_o;
  logic [4:0]  itype_o;
  logic        illegal_o;

  modport slave (
    input  ir_valid_i, ir_i, pc_i, rs1_data_i, rs2_data_i,
    output ir_ready_o, rs1_addr_o, rs2_addr_o,
           readd_a_o, readd_b_o, readd_pass_o,
           readin_a_o, readin_b_o, readin_pass_o,
           stage_o, ir_o, itype_o, illegal_o
  );

  modport master (
    output ir_valid_i, ir_i, pc_i, rs1_data_i, rs2_data_i,
    input  ir_ready_o, rs1_addr_o, rs2_addr_o,
           readd_a_o, readd_b_o, readd_pass_o,
           readin_a_o, readin_b_o, readin_pass_o,
           stage_o, ir_o, itype_o, illegal_o
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/operand-issue stage of the Pillar RV32I core; owns the 5-stage counter.
// DECODE_FASTFETCH_EN: also accept in WRITEBACK and jump 4 -> 1 (4 cycles/instruction).
`ifndef RTYPE
`define RTYPE 5'd1
`endif
`ifndef ITYPE
`define ITYPE 5'd2
`endif
`ifndef STYPE
`define STYPE 5'd3
`endif
`ifndef BTYPE
`define BTYPE 5'd4
`endif
`ifndef UTYPE
`define UTYPE 5'd5
`endif
`ifndef JTYPE
`define JTYPE 5'd6
`endif

module decode_issue (
  input logic            clk,
  input logic            reset,
  decode_issue_if.slave  bus
);

  // stage     | meaning
  // S_FETCH   | waiting for an instruction word
  // S_DECODE  | classify IR, read regfile, register operands
  // S_ISSUE   | load strobes high, operands valid for the ALU
  // S_EXEC    | ALU computes
  // S_WB      | writeback
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } stage_e;

  stage_e      stage_q;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] pass_q;
  logic [4:0]  itype_q;
  logic        sa_q;
  logic        sb_q;
  logic        sp_q;
  logic        illegal_q;

  logic        fetch_stage;
  logic        accept;
  logic [6:0]  opcode;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic [31:0] pass_d;
  logic [4:0]  itype_d;
  logic        sa_d;
  logic        sb_d;
  logic        sp_d;
  logic        legal_d;

`ifdef DECODE_FASTFETCH_EN
  assign fetch_stage = (stage_q == S_FETCH) || (stage_q == S_WB);
`else
  assign fetch_stage = (stage_q == S_FETCH);
`endif

  assign bus.ir_ready_o = fetch_stage && !reset;
  assign accept         = bus.ir_valid_i && bus.ir_ready_o;

  assign bus.rs1_addr_o = ir_q[19:15];
  assign bus.rs2_addr_o = ir_q[24:20];

  // x0 always reads as zero, whatever the regfile returns
  assign rs1_val = (ir_q[19:15] == 5'd0) ? 32'd0 : bus.rs1_data_i;
  assign rs2_val = (ir_q[24:20] == 5'd0) ? 32'd0 : bus.rs2_data_i;

  assign opcode = ir_q[6:0];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'd0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    a_d     = 32'd0;
    b_d     = 32'd0;
    pass_d  = 32'd0;
    itype_d = 5'd0;
    sa_d    = 1'b0;
    sb_d    = 1'b0;
    sp_d    = 1'b0;
    legal_d = 1'b1;
    case (opcode)
      7'b0110011: begin
        itype_d = `RTYPE;
        a_d = rs1_val;
        b_d = rs2_val;
        sa_d = 1'b1;
        sb_d = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        itype_d = `ITYPE;
        a_d = rs1_val;
        b_d = imm_i;
        sa_d = 1'b1;
        sb_d = 1'b1;
      end
      7'b0100011: begin
        itype_d = `STYPE;
        a_d = rs1_val;
        b_d = imm_s;
        pass_d = rs2_val;
        sa_d = 1'b1;
        sb_d = 1'b1;
        sp_d = 1'b1;
      end
      7'b1100011: begin
        itype_d = `BTYPE;
        a_d = rs1_val;
        b_d = rs2_val;
        pass_d = imm_b;
        sa_d = 1'b1;
        sb_d = 1'b1;
        sp_d = 1'b1;
      end
      7'b0110111: begin
        itype_d = `UTYPE;
        a_d = 32'd0;
        b_d = imm_u;
        sa_d = 1'b1;
        sb_d = 1'b1;
      end
      7'b0010111: begin
        itype_d = `UTYPE;
        a_d = pc_q;
        b_d = imm_u;
        sa_d = 1'b1;
        sb_d = 1'b1;
      end
      7'b1101111: begin
        itype_d = `JTYPE;
        a_d = pc_q;
        b_d = imm_j;
        pass_d = pc_q + 32'd4;
        sa_d = 1'b1;
        sb_d = 1'b1;
        sp_d = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= S_FETCH;
      ir_q      <= 32'd0;
      pc_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      pass_q    <= 32'd0;
      itype_q   <= 5'd0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      sp_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      sp_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (stage_q)
        S_FETCH: begin
          if (accept) begin
            ir_q    <= bus.ir_i;
            pc_q    <= bus.pc_i;
            stage_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal_d) begin
            // operands not used by this class keep their previous value
            if (sa_d) a_q <= a_d;
            if (sb_d) b_q <= b_d;
            if (sp_d) pass_q <= pass_d;
            itype_q <= itype_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sp_q    <= sp_d;
            stage_q <= S_ISSUE;
          end else begin
            illegal_q <= 1'b1;
            stage_q   <= S_FETCH;
          end
        end
        S_ISSUE: stage_q <= S_EXEC;
        S_EXEC:  stage_q <= S_WB;
        S_WB: begin
          if (accept) begin
            ir_q    <= bus.ir_i;
            pc_q    <= bus.pc_i;
            stage_q <= S_DECODE;
          end else begin
            stage_q <= S_FETCH;
          end
        end
        default: stage_q <= S_FETCH;
      endcase
    end
  end

  assign bus.stage_o       = stage_q;
  assign bus.ir_o          = ir_q;
  assign bus.itype_o       = itype_q;
  assign bus.readd_a_o     = a_q;
  assign bus.readd_b_o     = b_q;
  assign bus.readd_pass_o  = pass_q;
  assign bus.readin_a_o    = sa_q;
  assign bus.readin_b_o    = sb_q;
  assign bus.readin_pass_o = sp_q;
  assign bus.illegal_o     = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: driver pushes hand-computed issue results,
// a negedge monitor pops and compares whenever stage 2 or illegal_o is presented.
module tb_decode_issue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_issue_if bus ();
  decode_issue dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [4:0] IT_R = 5'd1, IT_I = 5'd2, IT_S = 5'd3,
                         IT_B = 5'd4, IT_U = 5'd5, IT_J = 5'd6;

  typedef struct {
    logic        ill;
    logic [2:0]  stb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [4:0]  it;
    logic [31:0] ir;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ill, input logic [2:0] stb, input logic [31:0] a, b, p,
                      input logic [4:0] it, input logic [31:0] ir, input logic [4:0] r1a, r2a);
    exp_t e;
    e.ill = ill; e.stb = stb; e.a = a; e.b = b; e.p = p;
    e.it = it; e.ir = ir; e.r1a = r1a; e.r2a = r2a;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ir, pc, r1, r2);
    int n = 0;
    while (bus.ir_ready_o !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("ready_before_send", {31'd0, bus.ir_ready_o}, 32'd1);
    bus.ir_valid_i = 1'b1;
    bus.ir_i = ir;
    bus.pc_i = pc;
    bus.rs1_data_i = r1;
    bus.rs2_data_i = r2;
    cyc();
    bus.ir_valid_i = 1'b0;
    chk("stage_decode", {29'd0, bus.stage_o}, 32'd1);
  endtask

  task automatic send(input logic [31:0] ir, pc, r1, r2, input bit ill);
    drive(ir, pc, r1, r2);
    cyc();
    if (ill) begin
      chk("stage_after_illegal", {29'd0, bus.stage_o}, 32'd0);
      chk("illegal_pulse", {31'd0, bus.illegal_o}, 32'd1);
      chk("ready_after_illegal", {31'd0, bus.ir_ready_o}, 32'd1);
      cyc();
      chk("illegal_one_cycle", {31'd0, bus.illegal_o}, 32'd0);
    end else begin
      chk("stage_issue", {29'd0, bus.stage_o}, 32'd2);
      cyc();
      chk("stage_exec", {29'd0, bus.stage_o}, 32'd3);
      cyc();
      chk("stage_wb", {29'd0, bus.stage_o}, 32'd4);
`ifdef DECODE_FASTFETCH_EN
      chk("ready_in_wb", {31'd0, bus.ir_ready_o}, 32'd1);
`else
      chk("ready_in_wb", {31'd0, bus.ir_ready_o}, 32'd0);
`endif
      cyc();
      chk("stage_wrap", {29'd0, bus.stage_o}, 32'd0);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.stage_o == 3'd2 || bus.illegal_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: actual stage=%0d illegal=%b required no output", bus.stage_o, bus.illegal_o);
      end else begin
        e = sb_q.pop_front();
        chk("illegal_flag", {31'd0, bus.illegal_o}, {31'd0, e.ill});
        chk("strobes", {29'd0, bus.readin_a_o, bus.readin_b_o, bus.readin_pass_o}, {29'd0, e.stb});
        chk("readd_a", bus.readd_a_o, e.a);
        chk("readd_b", bus.readd_b_o, e.b);
        chk("readd_pass", bus.readd_pass_o, e.p);
        if (!e.ill) begin
          chk("itype", {27'd0, bus.itype_o}, {27'd0, e.it});
          chk("ir_o", bus.ir_o, e.ir);
          chk("rs1_addr", {27'd0, bus.rs1_addr_o}, {27'd0, e.r1a});
          chk("rs2_addr", {27'd0, bus.rs2_addr_o}, {27'd0, e.r2a});
        end
      end
    end
    if (bus.stage_o == 3'd3)
      chk("strobes_low_exec", {29'd0, bus.readin_a_o, bus.readin_b_o, bus.readin_pass_o}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ir_valid_i = 1'b0;
    bus.ir_i = 32'd0;
    bus.pc_i = 32'd0;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    repeat (3) cyc();
    chk("rst_stage", {29'd0, bus.stage_o}, 32'd0);
    chk("rst_ready_low", {31'd0, bus.ir_ready_o}, 32'd0);
    chk("rst_readd_a", bus.readd_a_o, 32'd0);
    chk("rst_itype", {27'd0, bus.itype_o}, 32'd0);
    chk("rst_ir", bus.ir_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.ir_ready_o}, 32'd1);

    // ADDI x1,x0,5 : x0 forced to zero despite rs1 data
    push(0, 3'b110, 32'd0, 32'd5, 32'd0, IT_I, 32'h00500093, 5'd0, 5'd5);
    send(32'h00500093, 32'h0, 32'h0000DEAD, 32'h0, 0);
    // ADD x3,x1,x2
    push(0, 3'b110, 32'd7, 32'd9, 32'd0, IT_R, 32'h002081B3, 5'd1, 5'd2);
    send(32'h002081B3, 32'h4, 32'd7, 32'd9, 0);
    // SW x2,-4(x1)
    push(0, 3'b111, 32'h1000, 32'hFFFFFFFC, 32'hAB, IT_S, 32'hFE20AE23, 5'd1, 5'd2);
    send(32'hFE20AE23, 32'h8, 32'h1000, 32'hAB, 0);
    // ADD again: pass keeps 0xAB
    push(0, 3'b110, 32'd1, 32'd2, 32'hAB, IT_R, 32'h002081B3, 5'd1, 5'd2);
    send(32'h002081B3, 32'hC, 32'd1, 32'd2, 0);
    // JAL x1,+8 at 0x100
    push(0, 3'b111, 32'h100, 32'd8, 32'h104, IT_J, 32'h008000EF, 5'd0, 5'd8);
    send(32'h008000EF, 32'h100, 32'h0, 32'h0, 0);
    // LUI x5,0x12345 : A is zero even with nonzero rs1 data
    push(0, 3'b110, 32'd0, 32'h12345000, 32'h104, IT_U, 32'h123452B7, 5'd8, 5'd3);
    send(32'h123452B7, 32'h104, 32'h5555, 32'h0, 0);
    // AUIPC x1,1 at 0x200
    push(0, 3'b110, 32'h200, 32'h1000, 32'h104, IT_U, 32'h00001097, 5'd0, 5'd0);
    send(32'h00001097, 32'h200, 32'h0, 32'h0, 0);
    // BEQ x1,x2,+8
    push(0, 3'b111, 32'd3, 32'd4, 32'd8, IT_B, 32'h00208463, 5'd1, 5'd2);
    send(32'h00208463, 32'h204, 32'd3, 32'd4, 0);
    // illegal word: operands hold
    push(1, 3'b000, 32'd3, 32'd4, 32'd8, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    send(32'hFFFFFFFF, 32'h208, 32'd0, 32'd0, 1);

    // reset while in ISSUE
    push(0, 3'b110, 32'd0, 32'd5, 32'd8, IT_I, 32'h00500093, 5'd0, 5'd5);
    drive(32'h00500093, 32'h300, 32'h0000DEAD, 32'h0);
    cyc();
    chk("pre_reset_stage", {29'd0, bus.stage_o}, 32'd2);
    reset = 1'b1;
    cyc();
    chk("mid_rst_stage", {29'd0, bus.stage_o}, 32'd0);
    chk("mid_rst_strobes", {29'd0, bus.readin_a_o, bus.readin_b_o, bus.readin_pass_o}, 32'd0);
    chk("mid_rst_readd_a", bus.readd_a_o, 32'd0);
    chk("mid_rst_readd_b", bus.readd_b_o, 32'd0);
    chk("mid_rst_readd_pass", bus.readd_pass_o, 32'd0);
    chk("mid_rst_ir", bus.ir_o, 32'd0);
    chk("mid_rst_itype", {27'd0, bus.itype_o}, 32'd0);
    chk("mid_rst_ready_low", {31'd0, bus.ir_ready_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_mid_rst", {31'd0, bus.ir_ready_o}, 32'd1);

    // pass cleared by reset stays 0 for ADD
    push(0, 3'b110, 32'h11, 32'h22, 32'd0, IT_R, 32'h002081B3, 5'd1, 5'd2);
    send(32'h002081B3, 32'h0, 32'h11, 32'h22, 0);

`ifdef DECODE_FASTFETCH_EN
    push(0, 3'b110, 32'd0, 32'd5, 32'd0, IT_I, 32'h00500093, 5'd0, 5'd5);
    push(0, 3'b110, 32'd0, 32'd5, 32'd0, IT_I, 32'h00500093, 5'd0, 5'd5);
    bus.ir_valid_i = 1'b1;
    bus.ir_i = 32'h00500093;
    bus.pc_i = 32'h0;
    bus.rs1_data_i = 32'h0000DEAD;
    cyc();
    chk("ff_s1", {29'd0, bus.stage_o}, 32'd1);
    cyc();
    chk("ff_s2", {29'd0, bus.stage_o}, 32'd2);
    cyc();
    chk("ff_s3", {29'd0, bus.stage_o}, 32'd3);
    cyc();
    chk("ff_s4", {29'd0, bus.stage_o}, 32'd4);
    cyc();
    chk("ff_back_to_1", {29'd0, bus.stage_o}, 32'd1);
    bus.ir_valid_i = 1'b0;
    repeat (4) cyc();
    chk("ff_end", {29'd0, bus.stage_o}, 32'd0);
`endif

    repeat (2) cyc();
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

Decode and operand-issue stage of the Pillar multi-cycle RV32I core. Accepts one instruction word from fetch, classifies it, reads the register file, builds immediates, and presents operands A/B/pass to the ALU with one-cycle load strobes. Owns the core's stage counter, which is broadcast to the ALU and the other stage blocks.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ir_valid_i  in  1  fetch has an instruction word on ir_i
- ir_i  in  32  instruction word
- pc_i  in  32  PC of ir_i, sampled together with ir_i
- ir_ready_o  out  1  block accepts an instruction this cycle
- rs1_addr_o  out  5  register file read address 1 (combinational from latched IR)
- rs2_addr_o  out  5  register file read address 2
- rs1_data_i  in  32  register file read data 1 (combinational read)
- rs2_data_i  in  32  register file read data 2
- readd_a_o  out  32  ALU operand A
- readd_b_o  out  32  ALU operand B
- readd_pass_o  out  32  ALU pass-through value (store data, branch offset, link address)
- readin_a_o / readin_b_o / readin_pass_o  out  1 each  ALU load strobes
- stage_o  out  3  current stage, 0..4
- ir_o  out  32  latched instruction word
- itype_o  out  5  instruction class, encoded with the shared itype macros (RTYPE, ITYPE, STYPE, BTYPE, UTYPE, JTYPE)
- illegal_o  out  1  one-cycle pulse: unsupported opcode

## Operation
- Stage counter: 0 FETCH, 1 DECODE, 2 ISSUE, 3 EXECUTE, 4 WRITEBACK; 4 -> 0.
- FETCH: ir_ready_o = (stage==0) && !reset. On ir_valid_i && ir_ready_o: latch ir_o, pc, go to DECODE. Otherwise hold.
- DECODE: classify ir[6:0]; rs1_addr_o=ir[19:15], rs2_addr_o=ir[24:20]. Register value for address 0 forced to 0 regardless of rsN_data_i. Operands and itype_o registered at end of DECODE; go to ISSUE. Illegal opcode: illegal_o high for the following cycle, no strobes, go to FETCH.
- Operand selection (imm sign-extended to 32 bits):
  - 0110011 RTYPE: A=rs1, B=rs2; strobes A,B.
  - 0010011 / 0000011 / 1100111 ITYPE: A=rs1, B=imm[31:20]; strobes A,B.
  - 0100011 STYPE: A=rs1, B={ir[31:25],ir[11:7]}, pass=rs2; all strobes.
  - 1100011 BTYPE: A=rs1, B=rs2, pass=B-imm ({ir[31],ir[7],ir[30:25],ir[11:8],0}); all strobes.
  - 0110111 LUI: A=0; 0010111 AUIPC: A=pc; both B={ir[31:12],12'b0}, itype UTYPE; strobes A,B.
  - 1101111 JTYPE: A=pc, B=J-imm, pass=pc+4 (mod 2^32); all strobes.
- ISSUE: selected strobes high for exactly this cycle; readd_* valid. Unused readd_* hold previous value.
- EXECUTE, WRITEBACK: no issue activity; readd_* hold.
- Reset (any stage): next edge stage_o=0, all strobes 0, readd_*=0, ir_o=0, itype_o=0, illegal_o=0; in-flight instruction discarded.

## Timing
- Edge E0 accepts (stage 0). stage_o=1 after E0, 2 after E1, 3 after E2, 4 after E3, 0 after E4.
- Strobes and readd_* registered at E1, high during stage 2, sampled by ALU at E2; ALU computes at E3 (stage_i==3).
- Throughput: one instruction per 5 cycles minimum; FETCH waits indefinitely for ir_valid_i.
- Register file write by writeback lands at E4; next DECODE is no earlier than after E5, so no forwarding.
- illegal_o: high in the cycle after DECODE, stage_o=0 in that same cycle.

## Configuration
- DECODE_FASTFETCH_EN defined: ir_ready_o also high in WRITEBACK; acceptance there goes 4 -> 1 directly (4 cycles/instruction back-to-back). Regfile write at E4 is visible to the combinational read in the following DECODE.
- Undefined: acceptance only in FETCH; 4 -> 0 always.

## Test plan
- ADDI x1,x0,5 (0x00500093), rs1_data_i=0xDEAD -> stage 2: readd_a_o=0, readd_b_o=5, readin_a/b=1, readin_pass=0, itype ITYPE; strobes low in stage 3.
- ADD x3,x1,x2 (0x002081B3), rs1=7, rs2=9 -> readd_a_o=7, readd_b_o=9, itype RTYPE; stage_o sequence 0,1,2,3,4,0.
- SW x2,-4(x1) (0xFE20AE23), rs1=0x1000, rs2=0xAB -> A=0x1000, B=0xFFFFFFFC, pass=0xAB, all three strobes.
- JAL x1,+8 (0x008000EF) at pc 0x100 -> A=0x100, B=8, pass=0x104; LUI x5,0x12345 (0x123452B7) -> A=0, B=0x12345000.
- 0xFFFFFFFF -> illegal_o one cycle, no strobes, stage 1 -> 0, ir_ready_o high next cycle.
- Reset asserted during stage 2 -> next edge stage_o=0, strobes 0, readd_*=0; ir_ready_o low while reset high. With DECODE_FASTFETCH_EN and ir_valid_i held, stage sequence 1,2,3,4,1.
